// File: rtl/io_conditioner_if.sv
// io_conditioner_if: pin-side and core-side signals of the input conditioner.
//   raw_in     - asynchronous board pins, one bit per channel
//   sticky_clr - synchronous per-bit clear of sticky
//   level      - debounced stable level
//   rise/fall  - single-cycle pulses on a change of level
//   sticky     - set by rise, held until cleared
// master: the side that owns the pins and consumes the conditioned outputs.
// slave : the conditioner itself.
interface io_conditioner_if #(
  parameter int N_CH = 4
) ();
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] sticky_clr;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] sticky;

  modport master (
    output raw_in,
    output sticky_clr,
    input  level,
    input  rise,
    input  fall,
    input  sticky
  );

  modport slave (
    input  raw_in,
    input  sticky_clr,
    output level,
    output rise,
    output fall,
    output sticky
  );
endinterface

// File: rtl/io_conditioner.sv
// io_conditioner: per-channel synchroniser, debounce filter, edge pulses and
// sticky rise flag for asynchronous board inputs.
//   clock   - single clock
//   reset_n - asynchronous active-low reset, clears every flop
//   bus     - io_conditioner_if.slave (raw_in, sticky_clr in; level, rise,
//             fall, sticky out)
// Channels are independent. A channel whose BYPASS_MASK bit is set has no
// debounce counter and follows its synchronised input directly.
module io_conditioner #(
  parameter int              N_CH            = 4,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [N_CH-1:0] BYPASS_MASK     = '0
) (
  input logic            clock,
  input logic            reset_n,
  io_conditioner_if.slave bus
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   q;
    logic                   q_next;
    logic                   rise_r;
    logic                   fall_r;
    logic                   sticky_r;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], bus.raw_in[i]};
      end
    end

    assign s = sync[SYNC_STAGES-1];

    if (BYPASS_MASK[i]) begin : g_bypass
      assign q_next = s;
    end else begin : g_debounce
      localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt;

      // cnt counts consecutive cycles where s disagrees with q; any return
      // of s to q, or acceptance of the new level, restarts it.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
        end else if (s == q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign q_next = ((s != q) && (cnt == CNT_LAST)) ? s : q;
    end

    // Pulses are taken from q_next so they line up with the cycle in which
    // level first shows the new value.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q        <= 1'b0;
        rise_r   <= 1'b0;
        fall_r   <= 1'b0;
        sticky_r <= 1'b0;
      end else begin
        q        <= q_next;
        rise_r   <= q_next & ~q;
        fall_r   <= ~q_next & q;
        sticky_r <= (sticky_r & ~bus.sticky_clr[i]) | (q_next & ~q);
      end
    end

    assign bus.level[i]  = q;
    assign bus.rise[i]   = rise_r;
    assign bus.fall[i]   = fall_r;
    assign bus.sticky[i] = sticky_r;
  end

endmodule

// File: tb/tb_io_conditioner.sv
module tb_io_conditioner;
  localparam int            N    = 4;
  localparam int            SYNC = 2;
  localparam int            DEB  = 4;
  localparam logic [N-1:0]  BYP  = 4'b1000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  io_conditioner_if #(.N_CH(N)) bus ();

  io_conditioner #(
    .N_CH           (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .BYPASS_MASK    (BYP)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: level flips when the last D synchronised samples all
  // disagree with it; the synchronised sample used at an edge is the raw
  // value captured SYNC edges earlier (zero before reset release).
  logic [N-1:0] hist[$];
  logic [N-1:0] m_level, m_rise, m_fall, m_sticky;

  task automatic model_reset();
    hist.delete();
    m_level  = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_sticky = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] c);
    hist.push_back(r);
    for (int ch = 0; ch < N; ch++) begin
      int   d;
      bit   flip;
      logic v;
      d    = BYP[ch] ? 1 : DEB;
      flip = 1'b1;
      for (int k = 0; k < d; k++) begin
        int idx;
        idx = hist.size() - 1 - SYNC - k;
        v   = (idx >= 0) ? hist[idx][ch] : 1'b0;
        if (v == m_level[ch]) flip = 1'b0;
      end
      m_rise[ch]   = flip & ~m_level[ch];
      m_fall[ch]   = flip & m_level[ch];
      if (flip) m_level[ch] = ~m_level[ch];
      m_sticky[ch] = (m_sticky[ch] & ~c[ch]) | m_rise[ch];
    end
  endtask

  // Advance one edge; returns 1 time unit after the edge.
  task automatic tick();
    logic [N-1:0] r, c;
    r = bus.raw_in;
    c = bus.sticky_clr;
    @(posedge clock);
    #1;
    model_edge(r, c);
  endtask

  task automatic apply_reset();
    bus.raw_in     = '0;
    bus.sticky_clr = '0;
    reset_n        = 1'b0;
    #2;
    reset_n        = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.raw_in     = '1;
    bus.sticky_clr = '0;
    reset_n        = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.sticky} !== 16'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h",
               {bus.level, bus.rise, bus.fall, bus.sticky}, 16'h0);
    end
    bus.raw_in = '0;
    reset_n    = 1'b1;
    model_reset();
    tick();
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.sticky} !== 16'h0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h",
               {bus.level, bus.rise, bus.fall, bus.sticky}, 16'h0);
    end
  endtask

  task automatic test_press_release();
    apply_reset();
    bus.raw_in[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL press_model edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
      if (n == 5) begin
        checks++;
        if (bus.level[0] !== 1'b0) begin
          failures++;
          $display("FAIL press_early edge=5 level0 got=%b exp=0", bus.level[0]);
        end
      end
      if (n == 6) begin
        checks++;
        if ({bus.level[0], bus.rise[0], bus.sticky[0]} !== 3'b111) begin
          failures++;
          $display("FAIL press_rise edge=6 level/rise/sticky got=%b exp=111",
                   {bus.level[0], bus.rise[0], bus.sticky[0]});
        end
      end
      if (n == 7) begin
        checks++;
        if ({bus.level[0], bus.rise[0], bus.sticky[0]} !== 3'b101) begin
          failures++;
          $display("FAIL press_pulse edge=7 level/rise/sticky got=%b exp=101",
                   {bus.level[0], bus.rise[0], bus.sticky[0]});
        end
      end
    end
    bus.raw_in[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL release_model edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
      if (n == 6) begin
        checks++;
        if ({bus.level[0], bus.fall[0], bus.sticky[0]} !== 3'b011) begin
          failures++;
          $display("FAIL release_fall edge=6 level/fall/sticky got=%b exp=011",
                   {bus.level[0], bus.fall[0], bus.sticky[0]});
        end
      end
      if (n == 7) begin
        checks++;
        if ({bus.fall[0], bus.sticky[0]} !== 2'b01) begin
          failures++;
          $display("FAIL release_pulse edge=7 fall/sticky got=%b exp=01",
                   {bus.fall[0], bus.sticky[0]});
        end
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    bus.raw_in[1] = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      if (n == 4) bus.raw_in[1] = 1'b0;
      tick();
      checks++;
      if ({bus.level[1], bus.rise[1], bus.fall[1], bus.sticky[1]} !== 4'b0000 ||
          {bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL glitch edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
    end
  endtask

  task automatic test_bounce();
    int rises, falls, rise_edge;
    rises = 0; falls = 0; rise_edge = -1;
    apply_reset();
    // Toggles on edges 1..10 (last toggle at edge 10), held high afterwards.
    for (int n = 1; n <= 26; n++) begin
      bus.raw_in[2] = (n <= 10) ? n[0] : 1'b1;
      tick();
      if (bus.rise[2] === 1'b1) begin
        rises++;
        rise_edge = n;
      end
      if (bus.fall[2] === 1'b1) falls++;
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL bounce_model edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
    end
    checks++;
    if (rises != 1 || falls != 0 || rise_edge != 16) begin
      failures++;
      $display("FAIL bounce_pulses rises=%0d falls=%0d rise_edge=%0d exp 1/0/16",
               rises, falls, rise_edge);
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    bus.raw_in[3] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      bus.raw_in[3] = 1'b0;
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL bypass_model edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
      if (n == 2 || n == 3 || n == 4) begin
        logic [3:0] exp_v;
        exp_v = (n == 2) ? 4'b0000 : (n == 3) ? 4'b1101 : 4'b0011;
        checks++;
        if ({bus.level[3], bus.rise[3], bus.fall[3], bus.sticky[3]} !== exp_v) begin
          failures++;
          $display("FAIL bypass_timing edge=%0d level/rise/fall/sticky got=%b exp=%b", n,
                   {bus.level[3], bus.rise[3], bus.fall[3], bus.sticky[3]}, exp_v);
        end
      end
    end
  endtask

  task automatic test_sticky_clear();
    apply_reset();
    bus.raw_in[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      bus.sticky_clr[0] = (n == 6 || n == 7);
      tick();
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL sticky_model edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
      if (n >= 6) begin
        checks++;
        if (bus.sticky[0] !== (n == 6)) begin
          failures++;
          $display("FAIL sticky_clear edge=%0d sticky0 got=%b exp=%b", n, bus.sticky[0], (n == 6));
        end
      end
    end
    bus.sticky_clr = '0;
  endtask

  task automatic test_reset_mid();
    int rise_edge;
    rise_edge = -1;
    apply_reset();
    bus.raw_in[1] = 1'b1;
    repeat (8) tick();
    bus.raw_in[0] = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL resetmid_pre edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.level, bus.rise, bus.fall, bus.sticky} !== 16'h0) begin
      failures++;
      $display("FAIL resetmid_async got=%h exp=%h",
               {bus.level, bus.rise, bus.fall, bus.sticky}, 16'h0);
    end
    #2;
    reset_n = 1'b1;
    model_reset();
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (bus.rise[0] === 1'b1 && rise_edge < 0) rise_edge = n;
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL resetmid_post edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
    end
    checks++;
    if (rise_edge != 6 || bus.sticky[1:0] !== 2'b11) begin
      failures++;
      $display("FAIL resetmid_requal rise_edge=%0d sticky=%b exp 6/11", rise_edge, bus.sticky[1:0]);
    end
  endtask

  task automatic test_random();
    int edges_seen;
    edges_seen = 0;
    apply_reset();
    for (int n = 1; n <= 400; n++) begin
      if ($urandom_range(0, 2) == 0) bus.raw_in = bus.raw_in ^ N'($urandom_range(0, 15));
      bus.sticky_clr = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
      tick();
      if (m_rise != '0 || m_fall != '0) edges_seen++;
      checks++;
      if ({bus.level, bus.rise, bus.fall, bus.sticky} !== {m_level, m_rise, m_fall, m_sticky}) begin
        failures++;
        $display("FAIL random_model edge=%0d got=%h exp=%h", n,
                 {bus.level, bus.rise, bus.fall, bus.sticky}, {m_level, m_rise, m_fall, m_sticky});
      end
    end
    checks++;
    if (edges_seen == 0) begin
      failures++;
      $display("FAIL random_activity edges_seen=%0d exp>0", edges_seen);
    end
    bus.sticky_clr = '0;
  endtask

  initial begin
    bus.raw_in     = '0;
    bus.sticky_clr = '0;
    model_reset();
    test_reset();
    test_press_release();
    test_glitch();
    test_bounce();
    test_bypass();
    test_sticky_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
